// File: rtl/cpu7_ifu_ibuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu7_ifu_ibuf_pkg
// Description : Shared types for the instruction fetch buffer: per-entry
//               record layout and the intake FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu7_ifu_ibuf_pkg;

  localparam int unsigned c_pc_w    = 32;
  localparam int unsigned c_inst_w  = 32;
  localparam int unsigned c_exc_w   = 6;
  localparam int unsigned c_slots   = 4;

  // One buffered instruction: PC, opcode word, exception flag and code.
  typedef struct packed {
    logic [c_pc_w-1:0]   pc;
    logic [c_inst_w-1:0] inst;
    logic                ex;
    logic [c_exc_w-1:0]  exccode;
  } ibuf_entry_t;

  // Intake state: RUN accepts groups, EXHOLD blocks intake until a flush.
  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_EXHOLD = 1'b1
  } ibuf_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu7_ifu_ibuf_unpack.sv
`default_nettype none
// ============================================================================
// Module      : cpu7_ifu_ibuf_unpack
// Description : Combinational split of a 128-bit fetch group into four
//               per-slot entries with their PCs, plus the entry count.
//               An exception response collapses to a single entry.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu7_ifu_ibuf_unpack
  import cpu7_ifu_ibuf_pkg::*;
(
  input  logic [31:0]  i_pc,
  input  logic [1:0]   i_count,
  input  logic [127:0] i_rdata,
  input  logic         i_ex,
  input  logic [5:0]   i_exccode,
  output ibuf_entry_t  o_entries [c_slots],
  output logic [2:0]   o_n_in
);

  // Slot i sits at pc + 4*i; exception responses carry no instruction word.
  generate
    for (genvar i = 0; i < int'(c_slots); i++) begin : g_slot
      assign o_entries[i] = {i_pc + 32'(4 * i),
                             (i_ex ? 32'h0 : i_rdata[32*i +: 32]),
                             i_ex,
                             (i_ex ? i_exccode : 6'h0)};
    end
  endgenerate

  assign o_n_in = i_ex ? 3'd1 : ({1'b0, i_count} + 3'd1);

endmodule
`default_nettype wire

// File: rtl/cpu7_ifu_ibuf.sv
`default_nettype none
// ============================================================================
// Module      : cpu7_ifu_ibuf
// Description : Instruction fetch buffer. Unpacks 4-inst fetch groups into a
//               circular FIFO and presents one instruction per cycle. Flush
//               discards everything; a fetch exception freezes intake until
//               the next flush.
//               Build option CPU7_IBUF_BYPASS_EN: when empty, slot 0 of an
//               accepted group drives the outputs in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu7_ifu_ibuf
  import cpu7_ifu_ibuf_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_pc,
  input  logic [1:0]   in_count,
  input  logic [127:0] in_rdata,
  input  logic         in_ex,
  input  logic [5:0]   in_exccode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_pc,
  output logic [31:0]  out_inst,
  output logic         out_ex,
  output logic [5:0]   out_exccode
);

  localparam int unsigned c_aw = $clog2(DEPTH);

  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw:0]   r_occ;
  logic            r_live;
  ibuf_state_t     r_state;
  ibuf_state_t     w_state_nxt;
  ibuf_entry_t     r_mem [DEPTH];

  ibuf_entry_t     w_ent [c_slots];
  ibuf_entry_t     w_wdata [c_slots];
  logic [c_aw-1:0] w_widx [c_slots];
  ibuf_entry_t     w_head;
  logic [2:0]      w_n_in;
  logic [2:0]      w_n_wr;
  logic            w_push;
  logic            w_byp;
  logic            w_skip;
  logic            w_pop;
  logic            w_pop_fifo;
  logic            w_fifo_valid;
  logic            w_out_valid;

  cpu7_ifu_ibuf_unpack u_unpack (
    .i_pc      (in_pc),
    .i_count   (in_count),
    .i_rdata   (in_rdata),
    .i_ex      (in_ex),
    .i_exccode (in_exccode),
    .o_entries (w_ent),
    .o_n_in    (w_n_in)
  );

  // Room for a whole group is required; r_live keeps intake closed in reset.
  assign in_ready     = r_live && (r_state == ST_RUN) &&
                        (((c_aw+1)'(DEPTH) - r_occ) >= (c_aw+1)'(4));
  assign w_push       = in_valid && in_ready && !flush;
  assign w_fifo_valid = (r_occ != '0);

`ifdef CPU7_IBUF_BYPASS_EN
  assign w_byp = w_push && !w_fifo_valid;
`else
  assign w_byp = 1'b0;
`endif

  assign w_out_valid = w_fifo_valid || w_byp;
  assign w_pop       = w_out_valid && out_ready && !flush;
  // A bypassed slot 0 consumed this cycle never enters storage.
  assign w_skip      = w_byp && w_pop;
  assign w_pop_fifo  = w_pop && !w_skip;
  assign w_n_wr      = w_push ? (w_n_in - {2'b00, w_skip}) : 3'd0;
  assign w_head      = w_byp ? w_ent[0] : r_mem[r_rd_ptr];

  assign out_valid = w_out_valid;
  assign {out_pc, out_inst, out_ex, out_exccode} = w_out_valid ? w_head : '0;

  // Write data shifts down one slot when slot 0 was consumed via bypass.
  generate
    for (genvar i = 0; i < int'(c_slots); i++) begin : g_wsel
      assign w_widx[i] = r_wr_ptr + c_aw'(i);
      if (i < int'(c_slots) - 1) begin : g_shift
        assign w_wdata[i] = w_skip ? w_ent[i+1] : w_ent[i];
      end else begin : g_last
        assign w_wdata[i] = w_ent[i];
      end
    end
  endgenerate

  // Entry storage: no reset, only the accepted slots are written.
  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(c_slots); i++) begin
      if (3'(i) < w_n_wr) begin
        r_mem[w_widx[i]] <= w_wdata[i];
      end
    end
  end

  // Pointers and occupancy; flush clears both and wins over push/pop.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_occ    <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + c_aw'(w_n_wr);
        r_rd_ptr <= r_rd_ptr + c_aw'(w_pop_fifo);
        r_occ    <= r_occ + (c_aw+1)'(w_n_wr) - (c_aw+1)'(w_pop_fifo);
      end
    end
  end

  // Intake FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Intake FSM next state: an accepted exception holds intake until flush.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_RUN;
    end else if ((r_state == ST_RUN) && w_push && in_ex) begin
      w_state_nxt = ST_EXHOLD;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu7_ifu_ibuf.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu7_ifu_ibuf
// Description : Self-checking bench for cpu7_ifu_ibuf with a queue-based
//               reference model of the buffer contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu7_ifu_ibuf;

  logic         clock = 1'b0;
  logic         resetn;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_pc;
  logic [1:0]   in_count;
  logic [127:0] in_rdata;
  logic         in_ex;
  logic [5:0]   in_exccode;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_pc;
  logic [31:0]  out_inst;
  logic         out_ex;
  logic [5:0]   out_exccode;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [5:0]  code;
  } ment_t;

  ment_t q[$];
  bit    m_live = 1'b0;
  bit    m_hold = 1'b0;

  cpu7_ifu_ibuf dut (
    .clock       (clock),
    .resetn      (resetn),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_count    (in_count),
    .in_rdata    (in_rdata),
    .in_ex       (in_ex),
    .in_exccode  (in_exccode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_ex      (out_ex),
    .out_exccode (out_exccode)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit mrdy();
    return m_live && !m_hold && ((8 - q.size()) >= 4);
  endfunction

  task automatic drv(input bit v, input logic [31:0] pc, input logic [1:0] cnt,
                     input logic [127:0] d, input bit ex, input logic [5:0] code);
    in_valid   = v;
    in_pc      = pc;
    in_count   = cnt;
    in_rdata   = d;
    in_ex      = ex;
    in_exccode = code;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: check outputs mid-cycle against the model, then advance it.
  task automatic step(input string tag);
    ment_t nq[$];
    ment_t vis;
    bit    have, push, rdy, byp;
    @(negedge clock);
    rdy  = mrdy();
    push = in_valid && rdy && !flush;
    nq   = {};
    if (push) begin
      if (in_ex) begin
        nq.push_back('{in_pc, 32'h0, 1'b1, in_exccode});
      end else begin
        for (int i = 0; i <= int'(in_count); i++) begin
          nq.push_back('{in_pc + 32'(4 * i), in_rdata[32*i +: 32], 1'b0, 6'h0});
        end
      end
    end
    byp = 1'b0;
`ifdef CPU7_IBUF_BYPASS_EN
    byp = push && (q.size() == 0);
`endif
    have = (q.size() > 0) || byp;
    vis  = '{32'h0, 32'h0, 1'b0, 6'h0};
    if (q.size() > 0) vis = q[0];
    else if (byp) vis = nq[0];
    chk({tag, "/out"}, {out_valid, out_pc, out_inst, out_ex, out_exccode},
        have ? {1'b1, vis.pc, vis.inst, vis.ex, vis.code} : 71'h0);
    chk({tag, "/rdy"}, in_ready, rdy);
    if (!out_valid) chk({tag, "/zero"}, {out_pc, out_inst, out_ex, out_exccode}, 128'h0);
    @(posedge clock);
    if (!resetn) begin
      q = {};
      m_hold = 1'b0;
      m_live = 1'b0;
    end else begin
      m_live = 1'b1;
      if (flush) begin
        q = {};
        m_hold = 1'b0;
      end else begin
        if (have && out_ready) begin
          if (q.size() > 0) void'(q.pop_front());
          else void'(nq.pop_front());
        end
        foreach (nq[i]) q.push_back(nq[i]);
        if (push && in_ex) m_hold = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    int pushed;
    int iter;
    resetn    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drv(0, 32'h0, 2'd0, 128'h0, 0, 6'h0);

    // Reset state
    step("rst0");
    step("rst1");
    chk("rst_state", {out_valid, in_ready}, 2'b00);
    @(posedge clock); #1;
    resetn = 1'b1;
    step("rel");

    // 1: one full group streams out in order
    out_ready = 1'b1;
    drv(1, 32'h1c000000, 2'd3, {32'hdddd0004, 32'hcccc0003, 32'hbbbb0002, 32'haaaa0001}, 0, 6'h0);
    step("t1_push");
    drv(0, 32'h0, 2'd0, 128'h0, 0, 6'h0);
    repeat (5) step("t1_drain");

    // 2: fill to DEPTH, in_ready needs four free slots
    out_ready = 1'b0;
    drv(1, 32'h00000200, 2'd3, rnd128(), 0, 6'h0);
    step("t2_g0");
    drv(1, 32'h00000210, 2'd3, rnd128(), 0, 6'h0);
    step("t2_g1");
    drv(0, 32'h0, 2'd0, 128'h0, 0, 6'h0);
    chk("t2_full_rdy", in_ready, 1'b0);
    step("t2_idle");
    out_ready = 1'b1;
    step("t2_pop1");
    chk("t2_one_pop_rdy", in_ready, 1'b0);
    repeat (3) step("t2_pop");
    out_ready = 1'b0;
    chk("t2_four_pop_rdy", in_ready, 1'b1);
    step("t2_hold");
    out_ready = 1'b1;
    repeat (5) step("t2_drain");

    // 3: exception entry freezes intake until flush
    out_ready = 1'b0;
    drv(1, 32'h00000300, 2'd1, rnd128(), 0, 6'h0);
    step("t3_g");
    drv(1, 32'h00000100, 2'd2, rnd128(), 1, 6'h08);
    step("t3_ex");
    drv(0, 32'h0, 2'd0, 128'h0, 0, 6'h0);
    chk("t3_hold_rdy", in_ready, 1'b0);
    out_ready = 1'b1;
    repeat (4) step("t3_drain");
    chk("t3_still_hold", in_ready, 1'b0);
    drv(1, 32'h00000500, 2'd0, rnd128(), 0, 6'h0);
    step("t3_blocked");
    drv(0, 32'h0, 2'd0, 128'h0, 0, 6'h0);
    flush = 1'b1;
    step("t3_flush");
    flush = 1'b0;
    chk("t3_rdy_after", {in_ready, out_valid}, 2'b10);
    step("t3_after");

    // 4: flush beats a simultaneous push and pop
    out_ready = 1'b0;
    drv(1, 32'h00000600, 2'd2, rnd128(), 0, 6'h0);
    step("t4_fill");
    drv(1, 32'h00000700, 2'd3, rnd128(), 0, 6'h0);
    out_ready = 1'b1;
    flush     = 1'b1;
    step("t4_flush");
    flush = 1'b0;
    drv(0, 32'h0, 2'd0, 128'h0, 0, 6'h0);
    chk("t4_empty", out_valid, 1'b0);
    step("t4_post");

    // 5: random groups across pointer wrap, including PC wrap at 2^32
    out_ready = 1'b0;
    drv(1, 32'hfffffff8, 2'd3, rnd128(), 0, 6'h0);
    step("t5_pcwrap");
    pushed = 0;
    iter   = 0;
    while ((pushed < 20 || q.size() > 0) && iter < 1000) begin
      if (pushed < 20 && mrdy() && ($urandom_range(0, 3) != 0)) begin
        drv(1, $urandom & 32'hfffffffc, 2'($urandom_range(0, 3)), rnd128(), 0, 6'h0);
        pushed++;
      end else begin
        drv(0, 32'h0, 2'd0, 128'h0, 0, 6'h0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      step("t5_rand");
      iter++;
    end
    drv(0, 32'h0, 2'd0, 128'h0, 0, 6'h0);
    if (iter >= 1000) begin
      bad++;
      $display("FAIL t5_budget observed=%0d expected<1000", iter);
    end
    chk("t5_drained", out_valid, 1'b0);

    // 6: single-inst push into an empty buffer with out_ready high
    out_ready = 1'b1;
    drv(1, 32'h00000400, 2'd0, rnd128(), 0, 6'h0);
    step("t6_push");
    drv(0, 32'h0, 2'd0, 128'h0, 0, 6'h0);
    step("t6_next");
    step("t6_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
